gun_pos_gen: RTL and testbench

Converts digital joystick directions into the absolute crosshair position that the `williams2` core reads on its `gun_h`/`gun_v` inputs. It sits between the MiSTer joystick decode (`m_up/m_down/m_left/m_right`) and `williams2`, in the `clock_12` domain. The position is updated once per video frame, on the rising edge of `video_vblank`. Step size accelerates while a direction is held, and the position saturates at the playfield limits.

---
 rtl/gun_pos_gen.sv | 210 +++++++++++++++++++++
 tb/tb_gun_pos_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gun_pos_gen.sv
// Joystick-to-crosshair position generator for the williams2 gun inputs.
// Once per frame (vblank rising edge) each axis steps toward the pressed direction with hold acceleration.

// Per-axis position tracker: a saturating position with a step size that grows while a direction is held.
//   state  | meaning
//   S_IDLE | no direction on the last tick; step is 1 and the hold timer is reloaded
//   S_MOVE | a direction was seen on the last tick; the same direction keeps accelerating
module gun_pos_axis #(
   parameter int POS_W        = 6,
   parameter int CENTER       = 32,
   parameter int MAX_STEP     = 4,
   parameter int ACCEL_FRAMES = 8
) (
   input  logic             clock_12,
   input  logic             reset,
   input  logic             i_tick,
   input  logic             i_recenter,
   input  logic             i_neg,
   input  logic             i_pos,
   output logic [POS_W-1:0] o_pos
);

   typedef enum logic {S_IDLE, S_MOVE} state_t;
   typedef enum logic [1:0] {D_NONE, D_NEG, D_POS} dir_t;

   localparam int SW  = $clog2(MAX_STEP + 1);
   localparam int HW  = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
   localparam int PW1 = POS_W + 1;

   localparam logic [POS_W:0]   POS_MAX    = {1'b0, {POS_W{1'b1}}};
   localparam logic [POS_W-1:0] POS_CENTER = POS_W'(CENTER);
   localparam logic [SW-1:0]    STEP_ONE   = SW'(1);
   localparam logic [SW-1:0]    STEP_MAX   = SW'(MAX_STEP);
   localparam logic [HW-1:0]    HOLD_LOAD  = HW'(ACCEL_FRAMES - 1);
   // The first frame of a new direction already counts as one held frame.
   localparam logic [HW-1:0]    HOLD_ENTRY = (ACCEL_FRAMES > 1) ? HW'(ACCEL_FRAMES - 2) : '0;

   state_t           r_state;
   dir_t             r_dir_q;
   logic [POS_W-1:0] r_pos;
   logic [SW-1:0]    r_step;
   logic [HW-1:0]    r_hold_cnt;

   state_t           w_state_nxt;
   dir_t             w_dir_q_nxt;
   logic [POS_W-1:0] w_pos_nxt;
   logic [SW-1:0]    w_step_nxt;
   logic [HW-1:0]    w_hold_nxt;

   dir_t             w_dir;
   logic             w_same;
   logic [SW-1:0]    w_amt;
   logic [POS_W:0]   w_sum;
   logic [POS_W:0]   w_diff;
   logic [POS_W-1:0] w_pos_up;
   logic [POS_W-1:0] w_pos_dn;
   logic [POS_W-1:0] w_pos_move;

   always_comb begin
      w_dir = D_NONE;
      if (i_pos && !i_neg)
         w_dir = D_POS;
      else if (i_neg && !i_pos)
         w_dir = D_NEG;
   end

   // A change of direction always moves by one; only a continued hold uses the accumulated step.
   assign w_same     = (r_state == S_MOVE) && (w_dir == r_dir_q);
   assign w_amt      = w_same ? r_step : STEP_ONE;
   assign w_sum      = {1'b0, r_pos} + PW1'(w_amt);
   assign w_diff     = {1'b0, r_pos} - PW1'(w_amt);
   assign w_pos_up   = (w_sum > POS_MAX) ? POS_MAX[POS_W-1:0] : w_sum[POS_W-1:0];
   assign w_pos_dn   = w_diff[POS_W] ? '0 : w_diff[POS_W-1:0];
   assign w_pos_move = (w_dir == D_POS) ? w_pos_up : w_pos_dn;

   always_ff @(posedge clock_12 or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_dir_q    <= D_NONE;
         r_pos      <= POS_CENTER;
         r_step     <= STEP_ONE;
         r_hold_cnt <= HOLD_LOAD;
      end else begin
         r_state    <= w_state_nxt;
         r_dir_q    <= w_dir_q_nxt;
         r_pos      <= w_pos_nxt;
         r_step     <= w_step_nxt;
         r_hold_cnt <= w_hold_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_dir_q_nxt = r_dir_q;
      w_pos_nxt   = r_pos;
      w_step_nxt  = r_step;
      w_hold_nxt  = r_hold_cnt;

      if (i_recenter) begin
         w_state_nxt = S_IDLE;
         w_dir_q_nxt = D_NONE;
         w_pos_nxt   = POS_CENTER;
         w_step_nxt  = STEP_ONE;
         w_hold_nxt  = HOLD_LOAD;
      end else if (i_tick) begin
         if (w_dir == D_NONE) begin
            w_state_nxt = S_IDLE;
            w_dir_q_nxt = D_NONE;
            w_step_nxt  = STEP_ONE;
            w_hold_nxt  = HOLD_LOAD;
         end else if (!w_same) begin
            w_state_nxt = S_MOVE;
            w_dir_q_nxt = w_dir;
            w_pos_nxt   = w_pos_move;
            w_step_nxt  = STEP_ONE;
            w_hold_nxt  = HOLD_ENTRY;
         end else begin
            w_state_nxt = S_MOVE;
            w_pos_nxt   = w_pos_move;
            // Hold timer counts down; terminal count bumps the step and reloads.
            if (r_hold_cnt == '0) begin
               w_hold_nxt = HOLD_LOAD;
               w_step_nxt = (r_step >= STEP_MAX) ? STEP_MAX : r_step + STEP_ONE;
            end else begin
               w_hold_nxt = r_hold_cnt - HW'(1);
            end
         end
      end
   end

   assign o_pos = r_pos;

endmodule

module gun_pos_gen #(
   parameter int POS_W        = 6,
   parameter int CENTER       = 32,
   parameter int MAX_STEP     = 4,
   parameter int ACCEL_FRAMES = 8
) (
   input  logic             clock_12,
   input  logic             reset,
   input  logic             vblank,
   input  logic             left,
   input  logic             right,
   input  logic             up,
   input  logic             down,
   input  logic             recenter,
   output logic [POS_W-1:0] gun_h,
   output logic [POS_W-1:0] gun_v,
   output logic             moving
);

   logic r_vb_d;
   logic r_moving;
   logic w_tick;
   logic w_h_act;
   logic w_v_act;

   // r_vb_d resets high so a vblank already asserted at reset release does not count as a frame.
   assign w_tick  = vblank & ~r_vb_d;
   assign w_h_act = left ^ right;
   assign w_v_act = up ^ down;

   always_ff @(posedge clock_12 or posedge reset) begin
      if (reset) begin
         r_vb_d   <= 1'b1;
         r_moving <= 1'b0;
      end else begin
         r_vb_d <= vblank;
         if (recenter)
            r_moving <= 1'b0;
         else if (w_tick)
            r_moving <= w_h_act | w_v_act;
      end
   end

   gun_pos_axis #(
      .POS_W        (POS_W),
      .CENTER       (CENTER),
      .MAX_STEP     (MAX_STEP),
      .ACCEL_FRAMES (ACCEL_FRAMES)
   ) u_axis_h (
      .clock_12   (clock_12),
      .reset      (reset),
      .i_tick     (w_tick),
      .i_recenter (recenter),
      .i_neg      (left),
      .i_pos      (right),
      .o_pos      (gun_h)
   );

   gun_pos_axis #(
      .POS_W        (POS_W),
      .CENTER       (CENTER),
      .MAX_STEP     (MAX_STEP),
      .ACCEL_FRAMES (ACCEL_FRAMES)
   ) u_axis_v (
      .clock_12   (clock_12),
      .reset      (reset),
      .i_tick     (w_tick),
      .i_recenter (recenter),
      .i_neg      (up),
      .i_pos      (down),
      .o_pos      (gun_v)
   );

   assign moving = r_moving;

endmodule

// File: tb/tb_gun_pos_gen.sv
// Bench for gun_pos_gen: table-driven frame vectors, hand sequences for corner cases,
// and a reference model feeding a scoreboard for longer and random runs.
module tb_gun_pos_gen;

   localparam int POS_W    = 6;
   localparam int CENTER   = 32;
   localparam int MAX_STEP = 4;
   localparam int AF       = 8;
   localparam int PMAX     = 63;

   logic             clock_12 = 1'b0;
   logic             reset;
   logic             vblank;
   logic             left, right, up, down, recenter;
   logic [POS_W-1:0] gun_h, gun_v;
   logic             moving;

   always #5 clock_12 = ~clock_12;

   gun_pos_gen #(
      .POS_W        (POS_W),
      .CENTER       (CENTER),
      .MAX_STEP     (MAX_STEP),
      .ACCEL_FRAMES (AF)
   ) dut (
      .clock_12 (clock_12),
      .reset    (reset),
      .vblank   (vblank),
      .left     (left),
      .right    (right),
      .up       (up),
      .down     (down),
      .recenter (recenter),
      .gun_h    (gun_h),
      .gun_v    (gun_v),
      .moving   (moving)
   );

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int h;
      int v;
      int m;
   } exp_t;

   typedef struct {
      int kind;       // 0 = frame tick, 1 = recenter pulse without a tick
      bit l, r, u, d;
      int h, v, m;
   } vec_t;

   exp_t  sb_q[$];
   string sb_tag[$];
   vec_t  vecs[$];

   int m_pos[2], m_step[2], m_held[2], m_dq[2], m_mv;

   task automatic chk(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic int clamp(input int p);
      if (p < 0) return 0;
      if (p > PMAX) return PMAX;
      return p;
   endfunction

   task automatic model_reset();
      for (int a = 0; a < 2; a++) begin
         m_pos[a]  = CENTER;
         m_step[a] = 1;
         m_held[a] = 0;
         m_dq[a]   = 0;
      end
      m_mv = 0;
   endtask

   task automatic model_axis(input int a, input int d);
      if (d == 0) begin
         m_step[a] = 1;
         m_held[a] = 0;
         m_dq[a]   = 0;
      end else if (d != m_dq[a]) begin
         m_pos[a]  = clamp(m_pos[a] + d);
         m_step[a] = 1;
         m_held[a] = (AF == 1) ? 0 : 1;
         m_dq[a]   = d;
      end else begin
         m_pos[a] = clamp(m_pos[a] + d * m_step[a]);
         if (m_held[a] == AF - 1) begin
            m_held[a] = 0;
            m_step[a] = (m_step[a] + 1 > MAX_STEP) ? MAX_STEP : m_step[a] + 1;
         end else begin
            m_held[a] = m_held[a] + 1;
         end
      end
   endtask

   task automatic model_frame(input bit l, input bit r, input bit u, input bit d,
                              input bit rc, input bit tk);
      int dh, dv;
      dh = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
      dv = (d && !u) ? 1 : ((u && !d) ? -1 : 0);
      if (rc) begin
         model_reset();
      end else if (tk) begin
         model_axis(0, dh);
         model_axis(1, dv);
         m_mv = (dh != 0 || dv != 0) ? 1 : 0;
      end
   endtask

   task automatic sb_check();
      exp_t  e;
      string t;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL sb_empty: got 0 entries expected 1");
      end else begin
         e = sb_q.pop_front();
         t = sb_tag.pop_front();
         chk({t, "_h"}, int'(gun_h), e.h);
         chk({t, "_v"}, int'(gun_v), e.v);
         chk({t, "_mov"}, int'(moving), e.m);
      end
   endtask

   // One frame: inputs and vblank presented for one clock, outputs checked one clock after.
   // A negative e.h means "take the expectation from the reference model".
   task automatic drive_frame(input bit l, input bit r, input bit u, input bit d,
                              input bit rc, input bit tk, input exp_t e, input string tag);
      exp_t x;
      @(negedge clock_12);
      left = l; right = r; up = u; down = d;
      recenter = rc;
      vblank = tk;
      model_frame(l, r, u, d, rc, tk);
      if (e.h < 0) begin
         x.h = m_pos[0];
         x.v = m_pos[1];
         x.m = m_mv;
      end else begin
         x = e;
      end
      sb_q.push_back(x);
      sb_tag.push_back(tag);
      @(negedge clock_12);
      sb_check();
      left = 0; right = 0; up = 0; down = 0;
      recenter = 0;
      vblank = 0;
      @(negedge clock_12);
   endtask

   function automatic exp_t mk(input int h, input int v, input int m);
      exp_t e;
      e.h = h;
      e.v = v;
      e.m = m;
      return e;
   endfunction

   function automatic vec_t mv(input int kind, input bit l, input bit r, input bit u, input bit d,
                               input int h, input int v, input int m);
      vec_t x;
      x.kind = kind;
      x.l = l; x.r = r; x.u = u; x.d = d;
      x.h = h; x.v = v; x.m = m;
      return x;
   endfunction

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   exp_right[19];
      exp_t use_model;
      vec_t vv;

      exp_right = '{33, 34, 35, 36, 37, 38, 39, 40, 42, 44, 46, 48, 50, 52, 54, 56, 59, 62, 63};
      use_model = mk(-1, -1, -1);

      reset = 1; vblank = 1;
      left = 0; right = 0; up = 0; down = 0; recenter = 0;
      model_reset();

      // Reset released with vblank already high: no tick until a fresh rising edge.
      repeat (3) @(negedge clock_12);
      reset = 0;
      chk("rst_h", int'(gun_h), CENTER);
      chk("rst_v", int'(gun_v), CENTER);
      chk("rst_mov", int'(moving), 0);
      right = 1;
      repeat (4) @(negedge clock_12);
      chk("vb_high_no_tick_h", int'(gun_h), CENTER);
      chk("vb_high_no_tick_mov", int'(moving), 0);
      right = 0; vblank = 0;
      @(negedge clock_12);

      // Vector table: hold right, both-horizontal, diagonal, release.
      for (int i = 0; i < 19; i++) vecs.push_back(mv(0, 0, 1, 0, 0, exp_right[i], 32, 1));
      vecs.push_back(mv(1, 0, 0, 0, 0, 32, 32, 0));
      for (int i = 0; i < 5; i++) vecs.push_back(mv(0, 1, 1, 0, 0, 32, 32, 0));
      vecs.push_back(mv(0, 0, 1, 0, 0, 33, 32, 1));
      vecs.push_back(mv(1, 0, 0, 0, 0, 32, 32, 0));
      vecs.push_back(mv(0, 1, 0, 0, 1, 31, 33, 1));
      vecs.push_back(mv(0, 1, 0, 0, 1, 30, 34, 1));
      vecs.push_back(mv(0, 1, 0, 0, 1, 29, 35, 1));
      vecs.push_back(mv(0, 0, 0, 0, 0, 29, 35, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         vv = vecs[i];
         drive_frame(vv.l, vv.r, vv.u, vv.d, vv.kind == 1, vv.kind == 0,
                     mk(vv.h, vv.v, vv.m), $sformatf("vec%0d", i));
      end

      // Presses entirely between ticks are ignored.
      @(negedge clock_12);
      right = 1; down = 1;
      repeat (5) @(negedge clock_12);
      right = 0; down = 0;
      chk("between_ticks_h", int'(gun_h), 29);
      chk("between_ticks_v", int'(gun_v), 35);
      drive_frame(0, 0, 0, 0, 0, 1, use_model, "idle_tick");

      // Hold up to the floor, then reverse.
      drive_frame(0, 0, 0, 0, 1, 0, use_model, "rc_up");
      for (int i = 0; i < 40; i++) begin
         drive_frame(0, 0, 1, 0, 0, 1, use_model, $sformatf("up%0d", i));
         if (i == 7) chk("up_tick8_v", int'(gun_v), 24);
      end
      chk("up_floor_v", int'(gun_v), 0);
      drive_frame(0, 0, 0, 1, 0, 1, mk(32, 1, 1), "down_after_floor");

      // Step grows to MAX_STEP: left to 0, then right from 0.
      drive_frame(0, 0, 0, 0, 1, 0, use_model, "rc_accel");
      for (int i = 0; i < 20; i++) drive_frame(1, 0, 0, 0, 0, 1, use_model, $sformatf("left%0d", i));
      chk("left_floor_h", int'(gun_h), 0);
      for (int i = 0; i < 26; i++) begin
         drive_frame(0, 1, 0, 0, 0, 1, use_model, $sformatf("accel%0d", i));
         if (i == 23) chk("accel_tick24_h", int'(gun_h), 48);
         if (i == 24) chk("accel_tick25_h", int'(gun_h), 52);
      end

      // Recenter coinciding with a tick while right is held at 50.
      drive_frame(0, 0, 0, 0, 1, 0, use_model, "rc_pre50");
      for (int i = 0; i < 13; i++) drive_frame(0, 1, 0, 0, 0, 1, use_model, $sformatf("to50_%0d", i));
      chk("at50_h", int'(gun_h), 50);
      drive_frame(0, 1, 0, 0, 1, 1, mk(32, 32, 0), "rc_with_tick");
      drive_frame(0, 1, 0, 0, 0, 1, mk(33, 32, 1), "after_rc_tick");

      // Asynchronous reset in the middle of a tick cycle.
      drive_frame(0, 1, 0, 1, 0, 1, use_model, "pre_reset");
      @(negedge clock_12);
      vblank = 1; right = 1;
      #2 reset = 1;
      #1;
      chk("async_rst_h", int'(gun_h), CENTER);
      chk("async_rst_v", int'(gun_v), CENTER);
      chk("async_rst_mov", int'(moving), 0);
      model_reset();
      repeat (2) @(negedge clock_12);
      reset = 0;
      repeat (3) @(negedge clock_12);
      chk("post_rst_no_tick_h", int'(gun_h), CENTER);
      vblank = 0; right = 0;
      @(negedge clock_12);

      // Random frames against the model.
      for (int i = 0; i < 60; i++) begin
         drive_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 9) == 0, $urandom_range(0, 7) != 0,
                     use_model, $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
